alu_muldiv_seq: RTL
===================

# alu_muldiv_seq

Multi-cycle sequencer that runs unsigned multiply, divide and remainder through the shared 32-bit ALU (ADD=4'b0000, SUB=4'b0001) using shift-add and restoring shift-subtract, one ALU operation per cycle. It sits beside the EX stage. When an M-type instruction is issued it takes over the ALU operand/control inputs, holds the pipeline via `busy`, and returns a 32-bit result over a valid/ready handshake.

## Interface
- `XLEN`, 32, operand/result width; only 32 is supported.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, asynchronous and active-high.
- `flush`  in  1  synchronous cancel of any in-flight or pending operation.
- `req_valid`  in  1  EX stage presents an operation.
- `req_ready`  out  1  block can accept a request this cycle.
- `req_op`  in  2  operation: 00 MUL (low word), 01 MULHU (high word), 10 DIVU, 11 REMU.
- `req_a`, `req_b`  in  32 each  operands: multiplicand/multiplier, or dividend/divisor.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer takes the result.
- `rsp_data`  out  32  result.
- `busy`  out  1  high whenever the state is not IDLE; used as the EX stall and as the ALU mux select.
- `alu_a`, `alu_b`  out  32 each  ALU operands.
- `alu_control`  out  4  ALU opcode.
- `alu_result`  in  32  ALU output, combinational, same cycle.

## Operation
- States: IDLE, RUN, DONE. `cnt` is a 5-bit iteration counter.
- IDLE:
  - `req_ready = !flush`.
  - On `req_valid & req_ready`, latch the op and operands and set `cnt = 0`.
  - Divide op with `req_b == 0`: go directly to DONE. DIVU result = 32'hFFFFFFFF; REMU result = `req_a`.
  - Any other op: go to RUN.
- RUN, multiply:
  - Register pair `{hi, lo}` starts as `{0, req_a}`; `mcand = req_b`.
  - Each cycle: `alu_control = 0000`, `alu_a = hi`, `alu_b = lo[0] ? mcand : 0`.
  - Carry `c = (alu_result < hi)`, unsigned compare.
  - Update `{hi, lo} <= {c, alu_result, lo} >> 1`.
- RUN, divide:
  - Registers `R = 0`, `Q = req_a`, `D = req_b`.
  - Shift: `Rs = {R[30:0], Q[31]}` and `top = R[31]`.
  - Drive `alu_control = 0001`, `alu_a = Rs`, `alu_b = D`.
  - `ge = top | (Rs >= D)`.
  - Update `R <= ge ? alu_result : Rs`; `Q <= {Q[30:0], ge}`.
- RUN ends after 32 iterations: when `cnt == 31`, do the final update, go to DONE, and wrap `cnt` to 0.
- DONE:
  - `rsp_valid = 1`.
  - `rsp_data` by op: MUL = `lo`, MULHU = `hi`, DIVU = `Q`, REMU = `R`.
  - `rsp_valid & rsp_ready`: go to IDLE. Otherwise hold, with `rsp_data` stable.
- ALU outputs outside RUN: `alu_a = 0`, `alu_b = 0`, `alu_control = 0000`.
- `flush`:
  - In RUN or DONE: go to IDLE next cycle and discard the result. `rsp_valid` goes low that same next cycle.
  - In IDLE: blocks acceptance.
  - `flush` takes priority over both handshakes.

## Timing
- Reset values:
  - state IDLE, `cnt = 0`, all data registers 0.
  - `req_ready = 1`, `rsp_valid = 0`, `rsp_data = 0`, `busy = 0`.
  - `alu_a = 0`, `alu_b = 0`, `alu_control = 0000`.
- Normal op, accepted at edge T:
  - `busy` high from T+1.
  - RUN covers cycles T+1 through T+32.
  - `rsp_valid` high from T+33.
  - Latency from accept to `rsp_valid` is 33 cycles.
- Divide by zero: `rsp_valid` high at T+1.
- Result handshake at edge U: IDLE and `req_ready` high from U+1. Back-to-back throughput is one op per 34 cycles at best.
- `req_ready` is never high outside IDLE; a request held during `busy` waits.
- `rst` asserted at any point, mid-RUN included: outputs take reset values immediately (asynchronously). No response is produced for the aborted op.

## Test plan
- MUL 20×5, `rsp_ready = 1`: `rsp_data = 100`, `rsp_valid` exactly 33 cycles after accept. Check `alu_control = 0000` in every RUN cycle.
- MULHU 0xFFFFFFFF×0xFFFFFFFF gives 0xFFFFFFFE; MUL of the same operands gives 0x00000001. Checks the carry path.
- DIVU 23/5 gives 4; REMU 23/5 gives 3. DIVU 0x80000000/1 gives 0x80000000, which exercises the `top` bit path.
- DIVU 7/0 gives 0xFFFFFFFF and REMU 7/0 gives 7, both with `rsp_valid` 1 cycle after accept.
- Backpressure: hold `rsp_ready = 0` for 5 cycles in DONE. `rsp_valid` and `rsp_data` stay stable; a waiting `req_valid` is not accepted until the cycle after the result handshake.
- Cancels:
  - `flush` at RUN iteration 10: no `rsp_valid`, `busy` low and `req_ready` high the next cycle.
  - `rst` pulse mid-RUN: all outputs at reset values immediately.
  - The next op after each cancel produces a correct result.

Source files
------------

// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: unsigned MUL/MULHU/DIVU/REMU on the shared ALU, one ALU op per cycle; 33-cycle accept-to-result latency (1 cycle for divide by zero).
// Backpressure: result held stable in DONE until rsp_ready; req_ready only in IDLE, so a waiting request stalls.
module alu_muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_data,
  output logic            busy,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_control,
  input  logic [XLEN-1:0] alu_result
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;

  state_t          state, state_nxt;
  logic [4:0]      cnt;
  logic [1:0]      op;
  // hi/lo double as R/Q for divide; mcand doubles as the divisor D
  logic [XLEN-1:0] hi, lo, mcand;

  logic            is_div;
  logic [XLEN-1:0] rs;
  logic            top, ge, carry;

  assign is_div = op[1];
  assign rs     = {hi[XLEN-2:0], lo[XLEN-1]};
  assign top    = hi[XLEN-1];
  assign ge     = top | (rs >= mcand);
  assign carry  = (alu_result < hi);

  always_comb begin
    state_nxt   = state;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    rsp_data    = '0;
    busy        = (state != IDLE);
    alu_a       = '0;
    alu_b       = '0;
    alu_control = ALU_ADD;
    case (state)
      IDLE: begin
        req_ready = !flush;
        if (req_valid && !flush)
          state_nxt = (req_op[1] && req_b == '0) ? DONE : RUN;
      end
      RUN: begin
        if (is_div) begin
          alu_control = ALU_SUB;
          alu_a       = rs;
          alu_b       = mcand;
        end else begin
          alu_a = hi;
          alu_b = lo[0] ? mcand : '0;
        end
        if (cnt == 5'd31)
          state_nxt = DONE;
      end
      DONE: begin
        rsp_valid = 1'b1;
        case (op)
          2'b00:   rsp_data = lo;
          2'b01:   rsp_data = hi;
          2'b10:   rsp_data = lo;
          default: rsp_data = hi;
        endcase
        if (rsp_ready)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (flush)
      state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      op    <= '0;
      hi    <= '0;
      lo    <= '0;
      mcand <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            op    <= req_op;
            cnt   <= '0;
            mcand <= req_b;
            // Divide by zero resolves immediately: Q = all ones, R = dividend
            if (req_op[1] && req_b == '0) begin
              hi <= req_a;
              lo <= '1;
            end else begin
              hi <= '0;
              lo <= req_a;
            end
          end
        end
        RUN: begin
          cnt <= flush ? 5'd0 : cnt + 5'd1;
          if (is_div) begin
            hi <= ge ? alu_result : rs;
            lo <= {lo[XLEN-2:0], ge};
          end else begin
            hi <= {carry, alu_result[XLEN-1:1]};
            lo <= {alu_result[0], lo[XLEN-1:1]};
          end
        end
        default: ;
      endcase
    end
  end

endmodule
